// File: rtl/histogram_derivative_stream_if.sv
// ---------------------------------------------------------------------------
// histogram_derivative_stream_if
//
// Bundles the bin input stream, the derivative output stream and the
// per-frame statistics of histogram_derivative_stream.
//
// Signals:
//   clear        synchronous frame abort (source side)
//   bin          histogram bin value, unsigned (BIN_W)
//   bin_valid    bin is valid
//   bin_ready    block accepts bin
//   deriv        signed first difference (D_W = BIN_W+1)
//   idx          bin index of deriv
//   last         deriv belongs to bin NUM_BINS-1
//   deriv_valid  deriv is valid
//   deriv_ready  downstream accepts deriv
//   max_deriv / max_idx, min_deriv / min_idx   frame extremes
//   stats_valid  one-cycle pulse when the frame extremes update
//   zc_count     falling zero-crossing count (only with HISTDERIV_ZERO_CROSS_EN)
//
// Modports: master = source/sink driving the block, slave = the block itself.
// Optional macro: HISTDERIV_ZERO_CROSS_EN adds zc_count.
// ---------------------------------------------------------------------------
interface histogram_derivative_stream_if #(
    parameter int NUM_BINS = 256,
    parameter int BIN_W    = 16
);
    localparam int IDX_W = $clog2(NUM_BINS);
    localparam int D_W   = BIN_W + 1;

    logic                    clear;
    logic [BIN_W-1:0]        bin;
    logic                    bin_valid;
    logic                    bin_ready;
    logic signed [D_W-1:0]   deriv;
    logic [IDX_W-1:0]        idx;
    logic                    last;
    logic                    deriv_valid;
    logic                    deriv_ready;
    logic signed [D_W-1:0]   max_deriv;
    logic [IDX_W-1:0]        max_idx;
    logic signed [D_W-1:0]   min_deriv;
    logic [IDX_W-1:0]        min_idx;
    logic                    stats_valid;
`ifdef HISTDERIV_ZERO_CROSS_EN
    logic [IDX_W:0]          zc_count;

    modport master (
        output clear, bin, bin_valid, deriv_ready,
        input  bin_ready, deriv, idx, last, deriv_valid,
        input  max_deriv, max_idx, min_deriv, min_idx, stats_valid, zc_count
    );
    modport slave (
        input  clear, bin, bin_valid, deriv_ready,
        output bin_ready, deriv, idx, last, deriv_valid,
        output max_deriv, max_idx, min_deriv, min_idx, stats_valid, zc_count
    );
`else
    modport master (
        output clear, bin, bin_valid, deriv_ready,
        input  bin_ready, deriv, idx, last, deriv_valid,
        input  max_deriv, max_idx, min_deriv, min_idx, stats_valid
    );
    modport slave (
        input  clear, bin, bin_valid, deriv_ready,
        output bin_ready, deriv, idx, last, deriv_valid,
        output max_deriv, max_idx, min_deriv, min_idx, stats_valid
    );
`endif
endinterface

// File: rtl/histogram_derivative_stream.sv
// ---------------------------------------------------------------------------
// histogram_derivative_stream
//
// Streaming first-difference of a histogram. Bins arrive one per beat; each
// accepted bin k produces deriv = bin[k] - bin[k-1] (bin 0 -> 0) one cycle
// later through a single output register with pass-through backpressure.
// Over each frame of NUM_BINS bins the largest rising and falling edges
// (bins 1..N-1) are tracked and published in a one-cycle stats state after
// the final beat.
//
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset (clears outputs, stats, counter)
//   bus      histogram_derivative_stream_if.slave (see interface header)
//
// Parameters: NUM_BINS (>= 2), BIN_W. IDX_W and D_W are derived.
// Optional macro: HISTDERIV_ZERO_CROSS_EN adds a falling zero-crossing
// (peak) counter published as bus.zc_count alongside the stats.
// ---------------------------------------------------------------------------
module histogram_derivative_stream #(
    parameter int NUM_BINS = 256,
    parameter int BIN_W    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    histogram_derivative_stream_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_BINS);
    localparam int D_W   = BIN_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_RUN   = 2'd1,
        S_STATS = 2'd2
    } state_t;

    // Zero-extend both operands so the difference of two unsigned bins
    // always fits in BIN_W+1 signed bits; no saturation is ever needed.
    function automatic logic signed [D_W-1:0] bin_diff(
        input logic [BIN_W-1:0] cur,
        input logic [BIN_W-1:0] prev
    );
        return $signed({1'b0, cur}) - $signed({1'b0, prev});
    endfunction

    state_t                state, state_next;
    logic [IDX_W-1:0]      cnt, cnt_next;

    logic                  ready;
    logic                  accept;
    logic                  first_run;
    logic signed [D_W-1:0] diff;

    logic [BIN_W-1:0]      prev_bin_p0;

    logic signed [D_W-1:0] deriv_p1;
    logic [IDX_W-1:0]      idx_p1;
    logic                  last_p1;
    logic                  vld_p1;

    logic signed [D_W-1:0] run_max;
    logic [IDX_W-1:0]      run_max_idx;
    logic signed [D_W-1:0] run_min;
    logic [IDX_W-1:0]      run_min_idx;

    logic signed [D_W-1:0] max_deriv_q;
    logic [IDX_W-1:0]      max_idx_q;
    logic signed [D_W-1:0] min_deriv_q;
    logic [IDX_W-1:0]      min_idx_q;
    logic                  stats_vld;

`ifdef HISTDERIV_ZERO_CROSS_EN
    logic                  pos_pend;
    logic [IDX_W:0]        zc_run;
    logic [IDX_W:0]        zc_q;
`endif

    // Ready depends only on registered state and the downstream ready, never
    // on bin_valid. Gating with reset keeps the source from seeing an accept
    // while the block is held in reset.
    assign ready     = i_rst_n & (state != S_STATS) & (~vld_p1 | bus.deriv_ready);
    assign accept    = bus.bin_valid & ready & ~bus.clear;
    assign first_run = (cnt == ONE_IDX);
    assign diff      = bin_diff(bus.bin, prev_bin_p0);

    // ---- FSM state register ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_FIRST;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // ---- FSM next state / bin counter ----
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (bus.clear) begin
            state_next = S_FIRST;
            cnt_next   = '0;
        end else begin
            unique case (state)
                S_FIRST: begin
                    if (accept) begin
                        state_next = S_RUN;
                        cnt_next   = ONE_IDX;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (cnt == LAST_IDX) begin
                            state_next = S_STATS;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + ONE_IDX;
                        end
                    end
                end
                S_STATS: begin
                    state_next = S_FIRST;
                    cnt_next   = '0;
                end
                default: begin
                    state_next = S_FIRST;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ---- p0 -> p1: derivative output register, running and published stats ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prev_bin_p0 <= '0;
            deriv_p1    <= '0;
            idx_p1      <= '0;
            last_p1     <= 1'b0;
            vld_p1      <= 1'b0;
            run_max     <= '0;
            run_max_idx <= '0;
            run_min     <= '0;
            run_min_idx <= '0;
            max_deriv_q <= '0;
            max_idx_q   <= '0;
            min_deriv_q <= '0;
            min_idx_q   <= '0;
            stats_vld   <= 1'b0;
        end else begin
            stats_vld <= 1'b0;
            if (bus.clear) begin
                // Abort the frame: drop any pending output and the running
                // extremes, but leave the published stats alone.
                vld_p1      <= 1'b0;
                last_p1     <= 1'b0;
                run_max     <= '0;
                run_max_idx <= '0;
                run_min     <= '0;
                run_min_idx <= '0;
            end else begin
                if (accept) begin
                    vld_p1      <= 1'b1;
                    idx_p1      <= cnt;
                    prev_bin_p0 <= bus.bin;
                    if (state == S_FIRST) begin
                        deriv_p1 <= '0;
                        last_p1  <= 1'b0;
                    end else begin
                        deriv_p1 <= diff;
                        last_p1  <= (cnt == LAST_IDX);
                        // Strict compares: on ties the earliest index is kept.
                        if (first_run || (diff > run_max)) begin
                            run_max     <= diff;
                            run_max_idx <= cnt;
                        end
                        if (first_run || (diff < run_min)) begin
                            run_min     <= diff;
                            run_min_idx <= cnt;
                        end
                    end
                end else if (bus.deriv_ready) begin
                    vld_p1 <= 1'b0;
                end

                if (state == S_STATS) begin
                    max_deriv_q <= run_max;
                    max_idx_q   <= run_max_idx;
                    min_deriv_q <= run_min;
                    min_idx_q   <= run_min_idx;
                    stats_vld   <= 1'b1;
                end
            end
        end
    end

`ifdef HISTDERIV_ZERO_CROSS_EN
    // ---- p0 -> p1: falling zero-crossing counter ----
    // pos_pend remembers that the most recent non-zero derivative was
    // positive; a following negative derivative closes one peak.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pos_pend <= 1'b0;
            zc_run   <= '0;
            zc_q     <= '0;
        end else if (bus.clear) begin
            pos_pend <= 1'b0;
            zc_run   <= '0;
        end else begin
            if (accept) begin
                if (state == S_FIRST) begin
                    pos_pend <= 1'b0;
                    zc_run   <= '0;
                end else if (diff > 0) begin
                    pos_pend <= 1'b1;
                end else if (diff < 0) begin
                    if (pos_pend) begin
                        zc_run <= zc_run + 1'b1;
                    end
                    pos_pend <= 1'b0;
                end
            end
            if (state == S_STATS) begin
                zc_q <= zc_run;
            end
        end
    end

    assign bus.zc_count = zc_q;
`endif

    assign bus.bin_ready   = ready;
    assign bus.deriv       = deriv_p1;
    assign bus.idx         = idx_p1;
    assign bus.last        = last_p1;
    assign bus.deriv_valid = vld_p1;
    assign bus.max_deriv   = max_deriv_q;
    assign bus.max_idx     = max_idx_q;
    assign bus.min_deriv   = min_deriv_q;
    assign bus.min_idx     = min_idx_q;
    assign bus.stats_valid = stats_vld;

endmodule

// File: tb/tb_histogram_derivative_stream.sv
// ---------------------------------------------------------------------------
// tb_histogram_derivative_stream
//
// Self-checking bench for histogram_derivative_stream with NUM_BINS=8,
// BIN_W=16. Frames are streamed with optional random / forced downstream
// stalls; the collected output is compared against a plain-arithmetic
// reference of the first difference and the frame extremes.
// ---------------------------------------------------------------------------
module tb_histogram_derivative_stream;
    localparam int NB    = 8;
    localparam int BW    = 16;
    localparam int IDX_W = $clog2(NB);
    localparam int D_W   = BW + 1;

    logic clk;
    logic rst_n;

    histogram_derivative_stream_if #(.NUM_BINS(NB), .BIN_W(BW)) bus ();

    histogram_derivative_stream #(.NUM_BINS(NB), .BIN_W(BW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus and collected results
    int                    stim[$];
    logic signed [D_W-1:0] got_d[$];
    int                    got_i[$];
    logic                  got_l[$];
    int                    stats_cnt;
    int                    s_max, s_max_i, s_min, s_min_i, s_zc;
    int                    hold_err;
    int                    timeout;
    logic                  rdy_after_last;
    logic                  stall_rdy;

    // reference results
    int exp_d[$];
    int e_max, e_max_i, e_min, e_min_i, e_zc;

    function automatic void model();
        int last_sign;
        exp_d.delete();
        exp_d.push_back(0);
        for (int k = 1; k < stim.size(); k++) exp_d.push_back(stim[k] - stim[k-1]);
        e_max = exp_d[1]; e_max_i = 1; e_min = exp_d[1]; e_min_i = 1;
        for (int k = 2; k < exp_d.size(); k++) begin
            if (exp_d[k] > e_max) begin e_max = exp_d[k]; e_max_i = k; end
            if (exp_d[k] < e_min) begin e_min = exp_d[k]; e_min_i = k; end
        end
        e_zc = 0; last_sign = 0;
        for (int k = 1; k < exp_d.size(); k++) begin
            if (exp_d[k] > 0) last_sign = 1;
            else if (exp_d[k] < 0) begin
                if (last_sign == 1) e_zc++;
                last_sign = -1;
            end
        end
    endfunction

    // Streams stim[] into the block and collects every transferred output.
    // stall_pct: random downstream stall probability; forced_at: first cycle
    // of a forced 3-cycle downstream stall (-1 for none).
    task automatic run_stream(input int stall_pct, input int forced_at);
        int sent = 0; int cyc = 0; int tail = 0; bit done = 0; bit after_last = 0;
        logic held_v = 1'b0; logic signed [D_W-1:0] held_d = '0; int held_i = 0;
        got_d.delete(); got_i.delete(); got_l.delete();
        stats_cnt = 0; hold_err = 0; timeout = 0; rdy_after_last = 1'b1; stall_rdy = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            if (bus.stats_valid) begin
                stats_cnt++;
                s_max = int'(bus.max_deriv); s_max_i = int'(bus.max_idx);
                s_min = int'(bus.min_deriv); s_min_i = int'(bus.min_idx);
`ifdef HISTDERIV_ZERO_CROSS_EN
                s_zc = int'(bus.zc_count);
`endif
            end
            if (held_v && (!bus.deriv_valid || bus.deriv !== held_d || int'(bus.idx) != held_i))
                hold_err++;
            if (sent == stim.size() && !after_last) begin
                rdy_after_last = bus.bin_ready;
                after_last = 1;
            end
            if (sent == stim.size() && got_d.size() == stim.size()) begin
                tail++;
                if (tail > 3) done = 1;
            end
            if (!done) begin
                if (forced_at >= 0 && cyc >= forced_at && cyc < forced_at + 3)
                    bus.deriv_ready = 1'b0;
                else
                    bus.deriv_ready = ($urandom_range(0, 99) >= stall_pct);
                if (sent < stim.size()) begin
                    bus.bin_valid = 1'b1;
                    bus.bin = 16'(stim[sent]);
                end else begin
                    bus.bin_valid = 1'b0;
                end
                #1;
                if (forced_at >= 0 && cyc >= forced_at && cyc < forced_at + 3 && bus.deriv_valid)
                    stall_rdy = stall_rdy | bus.bin_ready;
                held_v = bus.deriv_valid && !bus.deriv_ready;
                held_d = bus.deriv;
                held_i = int'(bus.idx);
                if (bus.deriv_valid && bus.deriv_ready) begin
                    got_d.push_back(bus.deriv);
                    got_i.push_back(int'(bus.idx));
                    got_l.push_back(bus.last);
                end
                if (bus.bin_valid && bus.bin_ready) sent++;
                cyc++;
            end
        end
        if (!done) timeout = 1;
        bus.bin_valid = 1'b0;
        bus.deriv_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.deriv_valid !== 1'b0 || bus.deriv !== '0 || bus.idx !== '0 || bus.last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%0d i=%0d l=%b exp all 0",
                     bus.deriv_valid, bus.deriv, bus.idx, bus.last);
        end
        checks++;
        if (bus.max_deriv !== '0 || bus.min_deriv !== '0 || bus.max_idx !== '0 ||
            bus.min_idx !== '0 || bus.stats_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_stats got max=%0d@%0d min=%0d@%0d sv=%b exp all 0",
                     bus.max_deriv, bus.max_idx, bus.min_deriv, bus.min_idx, bus.stats_valid);
        end
        checks++;
        if (bus.bin_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b exp 0", bus.bin_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input string name, input int stall_pct, input int forced_at);
        int exp[8] = '{0, 10, 20, 0, -10, -20, 5, 0};
        stim = '{0, 10, 30, 30, 20, 0, 5, 5};
        run_stream(stall_pct, forced_at);
        checks++;
        if (timeout != 0 || got_d.size() != NB) begin
            errors++;
            $display("FAIL %s_count got %0d beats timeout=%0d exp %0d", name, got_d.size(), timeout, NB);
        end
        for (int k = 0; k < NB && k < got_d.size(); k++) begin
            checks++;
            if (int'(got_d[k]) != exp[k] || got_i[k] != k || got_l[k] !== (k == NB - 1)) begin
                errors++;
                $display("FAIL %s_beat%0d got d=%0d i=%0d l=%b exp d=%0d i=%0d l=%b",
                         name, k, got_d[k], got_i[k], got_l[k], exp[k], k, (k == NB - 1));
            end
        end
        checks++;
        if (stats_cnt != 1 || s_max != 20 || s_max_i != 2 || s_min != -20 || s_min_i != 5) begin
            errors++;
            $display("FAIL %s_stats got n=%0d max=%0d@%0d min=%0d@%0d exp n=1 max=20@2 min=-20@5",
                     name, stats_cnt, s_max, s_max_i, s_min, s_min_i);
        end
        checks++;
        if (hold_err != 0 || stall_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold got holderr=%0d stallready=%b exp 0 0", name, hold_err, stall_rdy);
        end
`ifdef HISTDERIV_ZERO_CROSS_EN
        checks++;
        if (s_zc != 1) begin
            errors++;
            $display("FAIL %s_zc got %0d exp 1", name, s_zc);
        end
`endif
    endtask

    task automatic test_extremes();
        stim = '{0, 65535, 0, 0, 0, 0, 0, 0};
        run_stream(0, -1);
        model();
        checks++;
        if (got_d.size() < 3 || got_d[1] !== 17'h0FFFF || got_d[2] !== 17'h10001) begin
            errors++;
            $display("FAIL extremes got n=%0d d1=%h d2=%h exp 0ffff 10001", got_d.size(),
                     (got_d.size() > 1) ? got_d[1] : '0, (got_d.size() > 2) ? got_d[2] : '0);
        end
        checks++;
        if (stats_cnt != 1 || s_max != e_max || s_max_i != e_max_i || s_min != e_min || s_min_i != e_min_i) begin
            errors++;
            $display("FAIL extremes_stats got max=%0d@%0d min=%0d@%0d exp max=%0d@%0d min=%0d@%0d",
                     s_max, s_max_i, s_min, s_min_i, e_max, e_max_i, e_min, e_min_i);
        end
    endtask

    task automatic test_ties();
        stim = '{0, 5, 10, 15, 20, 25, 30, 35};
        run_stream(0, -1);
        checks++;
        if (stats_cnt != 1 || s_max != 5 || s_max_i != 1 || s_min != 5 || s_min_i != 1) begin
            errors++;
            $display("FAIL ties_stats got n=%0d max=%0d@%0d min=%0d@%0d exp n=1 max=5@1 min=5@1",
                     stats_cnt, s_max, s_max_i, s_min, s_min_i);
        end
        checks++;
        if (rdy_after_last !== 1'b0) begin
            errors++;
            $display("FAIL ties_stats_ready got %b exp 0", rdy_after_last);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            stim.delete();
            for (int k = 0; k < NB; k++)
                stim.push_back((f % 2 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535)));
            run_stream(35, -1);
            model();
            checks++;
            if (timeout != 0 || got_d.size() != NB || hold_err != 0) begin
                errors++;
                $display("FAIL rand%0d_flow got n=%0d timeout=%0d holderr=%0d exp %0d 0 0",
                         f, got_d.size(), timeout, hold_err, NB);
            end
            for (int k = 0; k < NB && k < got_d.size(); k++) begin
                checks++;
                if (int'(got_d[k]) != exp_d[k] || got_i[k] != k || got_l[k] !== (k == NB - 1)) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d got d=%0d i=%0d l=%b exp d=%0d i=%0d",
                             f, k, got_d[k], got_i[k], got_l[k], exp_d[k], k);
                end
            end
            checks++;
            if (stats_cnt != 1 || s_max != e_max || s_max_i != e_max_i || s_min != e_min || s_min_i != e_min_i) begin
                errors++;
                $display("FAIL rand%0d_stats got n=%0d max=%0d@%0d min=%0d@%0d exp max=%0d@%0d min=%0d@%0d",
                         f, stats_cnt, s_max, s_max_i, s_min, s_min_i, e_max, e_max_i, e_min, e_min_i);
            end
`ifdef HISTDERIV_ZERO_CROSS_EN
            checks++;
            if (s_zc != e_zc) begin
                errors++;
                $display("FAIL rand%0d_zc got %0d exp %0d", f, s_zc, e_zc);
            end
`endif
        end
    endtask

    task automatic test_clear();
        int old_max, old_max_i, old_min, old_min_i;
        stim = '{3, 9, 1, 7, 7, 2, 8, 0};
        run_stream(0, -1);
        model();
        old_max = e_max; old_max_i = e_max_i; old_min = e_min; old_min_i = e_min_i;
        stim = '{100, 200, 50, 400};
        run_stream(0, -1);
        @(negedge clk);
        bus.clear = 1'b1; bus.bin_valid = 1'b1; bus.bin = 16'd999; bus.deriv_ready = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0; bus.bin_valid = 1'b0;
        checks++;
        if (bus.deriv_valid !== 1'b0 || bus.stats_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_outputs got v=%b sv=%b exp 0 0", bus.deriv_valid, bus.stats_valid);
        end
        checks++;
        if (int'(bus.max_deriv) != old_max || int'(bus.max_idx) != old_max_i ||
            int'(bus.min_deriv) != old_min || int'(bus.min_idx) != old_min_i) begin
            errors++;
            $display("FAIL clear_stats_held got max=%0d@%0d min=%0d@%0d exp max=%0d@%0d min=%0d@%0d",
                     bus.max_deriv, bus.max_idx, bus.min_deriv, bus.min_idx,
                     old_max, old_max_i, old_min, old_min_i);
        end
        stim.delete();
        for (int k = 0; k < NB; k++) stim.push_back(int'($urandom_range(0, 1000)));
        run_stream(20, -1);
        model();
        checks++;
        if (got_d.size() != NB || got_i[0] != 0 || got_d[0] !== '0) begin
            errors++;
            $display("FAIL clear_first got n=%0d i=%0d d=%0d exp n=%0d i=0 d=0",
                     got_d.size(), (got_i.size() > 0) ? got_i[0] : -1,
                     (got_d.size() > 0) ? got_d[0] : '0, NB);
        end
        for (int k = 1; k < NB && k < got_d.size(); k++) begin
            checks++;
            if (int'(got_d[k]) != exp_d[k] || got_i[k] != k) begin
                errors++;
                $display("FAIL clear_beat%0d got d=%0d i=%0d exp d=%0d i=%0d", k, got_d[k], got_i[k], exp_d[k], k);
            end
        end
        checks++;
        if (stats_cnt != 1 || s_max != e_max || s_max_i != e_max_i || s_min != e_min || s_min_i != e_min_i) begin
            errors++;
            $display("FAIL clear_new_stats got n=%0d max=%0d@%0d min=%0d@%0d exp max=%0d@%0d min=%0d@%0d",
                     stats_cnt, s_max, s_max_i, s_min, s_min_i, e_max, e_max_i, e_min, e_min_i);
        end
    endtask

    task automatic test_reset_mid_frame();
        stim = '{4, 60, 10};
        run_stream(0, -1);
        @(negedge clk);
        rst_n = 1'b0; bus.bin_valid = 1'b1; bus.bin = 16'd77;
        #1;
        checks++;
        if (bus.bin_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready got %b exp 0", bus.bin_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.bin_valid = 1'b0;
        checks++;
        if (bus.deriv_valid !== 1'b0 || bus.deriv !== '0 || bus.idx !== '0 || bus.last !== 1'b0 ||
            bus.max_deriv !== '0 || bus.max_idx !== '0 || bus.min_deriv !== '0 ||
            bus.min_idx !== '0 || bus.stats_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b d=%0d i=%0d max=%0d min=%0d exp all 0",
                     bus.deriv_valid, bus.deriv, bus.idx, bus.max_deriv, bus.min_deriv);
        end
`ifdef HISTDERIV_ZERO_CROSS_EN
        checks++;
        if (bus.zc_count !== '0) begin
            errors++;
            $display("FAIL midreset_zc got %0d exp 0", bus.zc_count);
        end
`endif
        test_basic("after_reset", 0, -1);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        bus.clear = 1'b0;
        bus.bin = '0;
        bus.bin_valid = 1'b0;
        bus.deriv_ready = 1'b1;
        test_reset();
        test_basic("basic", 0, -1);
        test_basic("backpressure", 0, 4);
        test_basic("random_stall", 40, -1);
        test_extremes();
        test_ties();
        test_random();
        test_clear();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
